instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter MEM_DEPTH, default 64: number of 32-bit instruction words held.
REQ-002 Parameter ADDR_W, default 6: address width, equal to log2(MEM_DEPTH).
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 Load_En  input  1: write Load_Data at the load pointer this cycle.
REQ-006 Load_Data  input  32: instruction word to store.
REQ-007 Start  input  1: begin issuing from address 0.
REQ-008 Stall  input  1: hold the current instruction and address.
REQ-009 Instruction_Code  output  32: registered instruction word presented to the main control unit.
REQ-010 Instr_Addr  output  ADDR_W: registered address of the word on Instruction_Code.
REQ-011 Instr_Valid  output  1: Instruction_Code holds a program instruction this cycle.
REQ-012 Prog_Len  output  ADDR_W+1: number of words loaded, range 0..MEM_DEPTH.
REQ-013 Load_Full  output  1: Prog_Len equals MEM_DEPTH.
REQ-014 Done  output  1: the last loaded instruction has been issued.

Function
REQ-015 The block SHALL implement the three-state FSM IDLE, RUN and DONE, with state held in a register.
REQ-016 In IDLE with Load_En=1 and Load_Full=0, the block SHALL write Load_Data to mem[Prog_Len] and increment Prog_Len by 1.
REQ-017 In IDLE with Load_Full=1, the block SHALL ignore Load_En, leaving memory and Prog_Len unchanged.
REQ-018 In RUN or DONE, the block SHALL ignore Load_En.
REQ-019 In IDLE with Start=1, Load_En=0 and Prog_Len>0, the block SHALL at the next edge enter RUN and set Instruction_Code=mem[0], Instr_Addr=0 and Instr_Valid=1.
REQ-020 In IDLE, when Start=1 and Load_En=1 in the same cycle, the load SHALL take effect and Start SHALL be ignored.
REQ-021 In IDLE with Start=1 and Prog_Len=0, the block SHALL ignore Start.
REQ-022 In RUN with Stall=1, the block SHALL hold Instruction_Code, Instr_Addr, Instr_Valid and the state unchanged.
REQ-023 In RUN with Stall=0 and Instr_Addr<Prog_Len-1, the block SHALL at the next edge set Instr_Addr to Instr_Addr+1 and Instruction_Code to mem[Instr_Addr+1], with one word issued per cycle.
REQ-024 In RUN with Stall=0 and Instr_Addr=Prog_Len-1, the block SHALL at the next edge enter DONE and set Instr_Valid=0, Instruction_Code=0 and Done=1.
REQ-025 Instr_Addr SHALL never wrap: with Prog_Len=MEM_DEPTH, the last address MEM_DEPTH-1 leads to DONE, not to address 0.
REQ-026 In DONE with Start=1, the block SHALL at the next edge re-enter RUN with the behaviour of REQ-019 and clear Done to 0.
REQ-027 Stall SHALL have no effect outside RUN.
REQ-028 Whenever Instr_Valid=0, Instruction_Code SHALL be 32'h0.
REQ-029 Done SHALL be 1 only in DONE.
REQ-030 Memory reads SHALL be registered, with zero added latency beyond the output register: a transition at edge N SHALL present the data at edge N.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set state=IDLE, Prog_Len=0, Instr_Addr=0, Instruction_Code=0, Instr_Valid=0, Done=0 and Load_Full=0.
REQ-032 Reset SHALL take priority over all inputs, including during RUN.
REQ-033 Reset SHALL NOT clear memory contents, but after reset the contents are unreachable until they are reloaded, because Prog_Len=0.

Verification
REQ-034 Scenario: load 3 words 0x20010005, 0x00221820, 0x8C640000, then Start -> over 3 consecutive cycles Instruction_Code shows those words at Instr_Addr 0, 1, 2 with Instr_Valid=1; next cycle Done=1, Instr_Valid=0, Instruction_Code=0.
REQ-035 Scenario: Stall=1 for 2 cycles while Instr_Addr=1 -> Instr_Addr stays 1 and Instruction_Code stays 0x00221820 for those cycles; the sequence then resumes with no word skipped.
REQ-036 Scenario: 65 loads with MEM_DEPTH=64 -> Prog_Len=64 and Load_Full=1; the 65th word is not stored; the run issues addresses 0..63, then Done=1 with no wrap to 0.
REQ-037 Scenario: Start with Prog_Len=0, and separately Start together with Load_En -> Start ignored; state stays IDLE; in the second case Prog_Len increments.
REQ-038 Scenario: reset asserted at Instr_Addr=2 during RUN -> next cycle all outputs are 0; a subsequent Start is ignored until a new load occurs.
REQ-039 Scenario: Start in DONE -> the program reissues from address 0 with Done=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable program memory that issues one registered
// instruction word per cycle from address 0 up to the last loaded word.
module instruction_fetch_unit #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Load_En,
  input  logic [31:0]       Load_Data,
  input  logic              Start,
  input  logic              Stall,
  output logic [31:0]       Instruction_Code,
  output logic [ADDR_W-1:0] Instr_Addr,
  output logic              Instr_Valid,
  output logic [ADDR_W:0]   Prog_Len,
  output logic              Load_Full,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [31:0]       mem [MEM_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [31:0]       code_p0, code_d;
  logic [ADDR_W-1:0] addr_p0, addr_d;
  logic              vld_p0, vld_d;
  logic              mem_we;
  logic              at_last;
  logic              full;
  logic [ADDR_W-1:0] addr_inc;

  assign full     = (prog_len_q == LEN_FULL);
  assign addr_inc = addr_p0 + ADDR_ONE;
  // Last word is compared against the length so the address can never wrap.
  assign at_last  = ({1'b0, addr_p0} == (prog_len_q - LEN_ONE));

  // Next-state, load control and next output word selection.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    code_d     = code_p0;
    addr_d     = addr_p0;
    vld_d      = vld_p0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Load_En) begin
          // A load always wins over Start in the same cycle.
          if (!full) begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + LEN_ONE;
          end
        end else if (Start && (prog_len_q != '0)) begin
          state_d = RUN;
          addr_d  = '0;
          code_d  = mem[0];
          vld_d   = 1'b1;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (at_last) begin
            state_d = DONE;
            code_d  = '0;
            vld_d   = 1'b0;
          end else begin
            addr_d = addr_inc;
            code_d = mem[addr_inc];
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          addr_d  = '0;
          code_d  = mem[0];
          vld_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State, program length and output register stage (p0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      code_p0    <= '0;
      addr_p0    <= '0;
      vld_p0     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      code_p0    <= code_d;
      addr_p0    <= addr_d;
      vld_p0     <= vld_d;
    end
  end

  // Program memory write port; contents survive reset but become unreachable.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[prog_len_q[ADDR_W-1:0]] <= Load_Data;
    end
  end

  assign Instruction_Code = code_p0;
  assign Instr_Addr       = addr_p0;
  assign Instr_Valid      = vld_p0;
  assign Prog_Len         = prog_len_q;
  assign Load_Full        = full;
  assign Done             = (state_q == DONE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a reference model pushes the
// expected outputs for each driven cycle, a monitor pops and compares them.
module tb_instruction_fetch_unit;

  localparam int MEM_DEPTH = 64;
  localparam int ADDR_W    = 6;

  localparam logic [31:0] W0 = 32'h20010005;
  localparam logic [31:0] W1 = 32'h00221820;
  localparam logic [31:0] W2 = 32'h8C640000;
  localparam logic [31:0] W3 = 32'h12345678;

  logic              clk;
  logic              reset;
  logic              Load_En;
  logic [31:0]       Load_Data;
  logic              Start;
  logic              Stall;
  logic [31:0]       Instruction_Code;
  logic [ADDR_W-1:0] Instr_Addr;
  logic              Instr_Valid;
  logic [ADDR_W:0]   Prog_Len;
  logic              Load_Full;
  logic              Done;

  instruction_fetch_unit #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .Load_En(Load_En), .Load_Data(Load_Data),
    .Start(Start), .Stall(Stall), .Instruction_Code(Instruction_Code),
    .Instr_Addr(Instr_Addr), .Instr_Valid(Instr_Valid), .Prog_Len(Prog_Len),
    .Load_Full(Load_Full), .Done(Done)
  );

  typedef struct {
    logic [31:0] code;
    int          addr;
    logic        vld;
    int          len;
    logic        full;
    logic        done;
    logic        chk_addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state
  logic [31:0] m_mem [MEM_DEPTH];
  int          m_state = 0;  // 0 idle, 1 run, 2 done
  int          m_len   = 0;
  int          m_addr  = 0;
  logic [31:0] m_code  = '0;
  logic        m_vld   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs just after each edge with the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("code",  Instruction_Code, e.code);
      check_val("valid", 32'(Instr_Valid), 32'(e.vld));
      check_val("len",   32'(Prog_Len),    e.len);
      check_val("full",  32'(Load_Full),   32'(e.full));
      check_val("done",  32'(Done),        32'(e.done));
      if (e.vld || e.chk_addr) check_val("addr", 32'(Instr_Addr), e.addr);
    end
  end

  task automatic launch();
    m_state = 1;
    m_addr  = 0;
    m_code  = m_mem[0];
    m_vld   = 1'b1;
  endtask

  // Drive one cycle of stimulus, advance the model, queue the expected outputs.
  task automatic cycle(input logic le, input logic [31:0] ld, input logic st,
                       input logic sl, input logic rs);
    exp_t e;
    @(negedge clk);
    Load_En = le; Load_Data = ld; Start = st; Stall = sl; reset = rs;
    e.chk_addr = 1'b0;
    if (rs) begin
      m_state = 0; m_len = 0; m_addr = 0; m_code = '0; m_vld = 1'b0;
      e.chk_addr = 1'b1;
    end else if (m_state == 0) begin
      if (le) begin
        if (m_len < MEM_DEPTH) begin
          m_mem[m_len] = ld;
          m_len++;
        end
      end else if (st && m_len > 0) begin
        launch();
      end
    end else if (m_state == 1) begin
      if (!sl) begin
        if (m_addr == m_len - 1) begin
          m_state = 2; m_code = '0; m_vld = 1'b0;
        end else begin
          m_addr++;
          m_code = m_mem[m_addr];
        end
      end
    end else if (st) begin
      launch();
    end
    e.code = m_code; e.addr = m_addr; e.vld = m_vld; e.len = m_len;
    e.full = (m_len == MEM_DEPTH); e.done = (m_state == 2);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    Load_En = 1'b0; Load_Data = '0; Start = 1'b0; Stall = 1'b0; reset = 1'b1;

    // Reset state
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_val("rst_len", 32'(Prog_Len), 0);

    // Start with empty program is ignored
    cycle(0, 0, 1, 0, 0);
    check_val("empty_start_valid", 32'(Instr_Valid), 0);

    // Start together with a load: load wins
    cycle(1, W0, 1, 0, 0);
    check_val("start_load_len", 32'(Prog_Len), 1);
    check_val("start_load_valid", 32'(Instr_Valid), 0);
    cycle(1, W1, 0, 0, 0);
    cycle(1, W2, 0, 0, 0);

    // Straight run of three words
    cycle(0, 0, 1, 0, 0);
    check_val("run_w0", Instruction_Code, W0);
    cycle(0, 0, 0, 0, 0);
    check_val("run_w1", Instruction_Code, W1);
    cycle(0, 0, 0, 0, 0);
    check_val("run_w2", Instruction_Code, W2);
    cycle(0, 0, 0, 0, 0);
    check_val("run_done", 32'(Done), 1);

    // Load and Stall have no effect in DONE
    cycle(1, 32'hDEADBEEF, 0, 1, 0);
    check_val("done_load_len", 32'(Prog_Len), 3);

    // Restart from DONE with a two-cycle stall at address 1
    cycle(0, 0, 1, 0, 0);
    check_val("restart_done_clr", 32'(Done), 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check_val("stall_addr", 32'(Instr_Addr), 1);
    check_val("stall_code", Instruction_Code, W1);
    cycle(0, 0, 0, 0, 0);
    check_val("resume_w2", Instruction_Code, W2);
    cycle(0, 0, 0, 0, 0);

    // Reset in the middle of a run, then Start is ignored until a reload
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check_val("midrun_rst_code", Instruction_Code, 0);
    cycle(0, 0, 1, 0, 0);
    check_val("post_rst_start", 32'(Instr_Valid), 0);
    cycle(1, W3, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check_val("reload_w3", Instruction_Code, W3);
    cycle(0, 0, 0, 0, 0);

    // Full memory: 65 loads, only 64 stored; run ends without wrapping
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < MEM_DEPTH + 1; i++) cycle(1, $urandom, 0, 0, 0);
    check_val("full_len", 32'(Prog_Len), MEM_DEPTH);
    check_val("full_flag", 32'(Load_Full), 1);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < MEM_DEPTH; i++) cycle(0, 0, 0, logic'(i == 30), 0);
    check_val("last_addr", 32'(Instr_Addr), MEM_DEPTH - 1);
    cycle(0, 0, 0, 0, 0);
    check_val("full_done", 32'(Done), 1);
    check_val("full_done_valid", 32'(Instr_Valid), 0);
    cycle(0, 0, 0, 0, 0);

    @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
